ext_unit_arbiter: RTL and testbench

//  Shares the single 16->32 immediate extension unit between two requesters:
//  req0 = ID-stage immediate path, req1 = MEM-stage halfword load path.

---
 rtl/ext_unit_arbiter_if.sv | 52 +++++
 rtl/ext_unit_arbiter.sv | 129 ++++++++++++
 tb/tb_ext_unit_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_unit_arbiter_if.sv
// ext_unit_arbiter_if: bundles the two requester channels, the extension-unit
// drive/return pair and the response channel of ext_unit_arbiter.
// slave = arbiter side, master = surrounding pipeline / environment side.
interface ext_unit_arbiter_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [IN_W-1:0]  req0_data;
    logic             req0_extop;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [IN_W-1:0]  req1_data;
    logic             req1_extop;
    logic [TAG_W-1:0] req1_tag;

    logic [IN_W-1:0]  ext_i_data;
    logic             ext_extop;
    logic [OUT_W-1:0] ext_out;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [OUT_W-1:0] rsp_data;
    logic             rsp_src;
    logic [TAG_W-1:0] rsp_tag;

    modport slave (
        input  req0_valid, req0_data, req0_extop, req0_tag,
        output req0_ready,
        input  req1_valid, req1_data, req1_extop, req1_tag,
        output req1_ready,
        output ext_i_data, ext_extop,
        input  ext_out,
        output rsp_valid, rsp_data, rsp_src, rsp_tag,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_data, req0_extop, req0_tag,
        input  req0_ready,
        output req1_valid, req1_data, req1_extop, req1_tag,
        input  req1_ready,
        input  ext_i_data, ext_extop,
        output ext_out,
        input  rsp_valid, rsp_data, rsp_src, rsp_tag,
        output rsp_ready
    );
endinterface

// File: rtl/ext_unit_arbiter.sv
// ext_unit_arbiter: shares one 16->32 extension unit between the ID-stage
// immediate path (req0) and the MEM-stage halfword load path (req1).
// Round-robin arbitration, IDLE -> EXT -> RESP sequencing, registered
// response tagged with source and transaction tag.
// Optional build macro EXT_ARB_OVERLAP_EN: allows a new request to be
// accepted in the same cycle the response is consumed (RESP -> EXT).
module ext_unit_arbiter #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    ext_unit_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXT  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IN_W-1:0]  op_q, op_d;
    logic             extop_q, extop_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             src_q, src_d;
    logic             last_grant_q, last_grant_d;
    logic [OUT_W-1:0] rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic             rsp_src_q, rsp_src_d;

    logic             any_valid;
    logic             grant_sel;
    logic             arb_en;
    logic             accept;

    // Round-robin pick and the window in which a grant may be issued
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        // On a tie the requester that did not win last time gets the grant
        if (bus.req0_valid && bus.req1_valid) begin
            grant_sel = ~last_grant_q;
        end else begin
            grant_sel = bus.req1_valid;
        end
`ifdef EXT_ARB_OVERLAP_EN
        arb_en = rst_n && ((state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready));
`else
        arb_en = rst_n && (state_q == IDLE);
`endif
        accept = arb_en && any_valid;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = EXT;
            EXT:     state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = accept ? EXT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture on accept, response capture at the end of EXT
    always_comb begin
        op_d         = op_q;
        extop_d      = extop_q;
        tag_d        = tag_q;
        src_d        = src_q;
        last_grant_d = last_grant_q;
        rsp_data_d   = rsp_data_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_src_d    = rsp_src_q;
        if (accept) begin
            op_d         = grant_sel ? bus.req1_data  : bus.req0_data;
            extop_d      = grant_sel ? bus.req1_extop : bus.req0_extop;
            tag_d        = grant_sel ? bus.req1_tag   : bus.req0_tag;
            src_d        = grant_sel;
            last_grant_d = grant_sel;
        end
        // Result passes through verbatim; the unit already produced OUT_W bits
        if (state_q == EXT) begin
            rsp_data_d = bus.ext_out;
            rsp_tag_d  = tag_q;
            rsp_src_d  = src_q;
        end
    end

    // State and datapath registers; reset discards any in-flight request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= '0;
            extop_q      <= 1'b0;
            tag_q        <= '0;
            src_q        <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_data_q   <= '0;
            rsp_tag_q    <= '0;
            rsp_src_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            extop_q      <= extop_d;
            tag_q        <= tag_d;
            src_q        <= src_d;
            last_grant_q <= last_grant_d;
            rsp_data_q   <= rsp_data_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_src_q    <= rsp_src_d;
        end
    end

    // Outputs: extension-unit inputs held from the operand registers so they
    // never glitch between transactions
    always_comb begin
        bus.req0_ready = accept && !grant_sel;
        bus.req1_ready = accept && grant_sel;
        bus.ext_i_data = op_q;
        bus.ext_extop  = extop_q;
        bus.rsp_valid  = (state_q == RESP);
        bus.rsp_data   = rsp_data_q;
        bus.rsp_src    = rsp_src_q;
        bus.rsp_tag    = rsp_tag_q;
    end

endmodule

// File: tb/tb_ext_unit_arbiter.sv
// tb_ext_unit_arbiter: directed table-driven bench for ext_unit_arbiter plus
// hand-written sequences for tie alternation, response backpressure and
// reset during EXT. Honours EXT_ARB_OVERLAP_EN for the response spacing.
`timescale 1ns/1ps
module tb_ext_unit_arbiter;
    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int TAG_W = 4;
`ifdef EXT_ARB_OVERLAP_EN
    localparam int RSP_PERIOD = 2;
`else
    localparam int RSP_PERIOD = 3;
`endif

    typedef struct {
        logic        v0;
        logic [15:0] d0;
        logic        e0;
        logic [3:0]  t0;
        logic        v1;
        logic [15:0] d1;
        logic        e1;
        logic [3:0]  t1;
        logic        exp_src;
        logic [31:0] exp_data;
        logic [3:0]  exp_tag;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    vec_t        tbl [8];
    logic        src_seen [20];
    logic [31:0] data_seen [20];
    int          t_seen [20];
    int          got;
    int          cyc;
    int          cnt0;
    int          cnt1;
    logic [31:0] held_data;
    int          wait_n;

    ext_unit_arbiter_if #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) bus ();

    ext_unit_arbiter #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural extension unit
    assign bus.ext_out = bus.ext_extop ? {{(OUT_W-IN_W){bus.ext_i_data[IN_W-1]}}, bus.ext_i_data}
                                       : {{(OUT_W-IN_W){1'b0}}, bus.ext_i_data};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drop_valids();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [15:0] exp_op;
        logic        exp_x;
        exp_op = v.exp_src ? v.d1 : v.d0;
        exp_x  = v.exp_src ? v.e1 : v.e0;
        @(negedge clk);
        bus.req0_valid = v.v0; bus.req0_data = v.d0; bus.req0_extop = v.e0; bus.req0_tag = v.t0;
        bus.req1_valid = v.v1; bus.req1_data = v.d1; bus.req1_extop = v.e1; bus.req1_tag = v.t1;
        #1;
        check($sformatf("v%0d_ready0", idx), 32'(bus.req0_ready), 32'(!v.exp_src));
        check($sformatf("v%0d_ready1", idx), 32'(bus.req1_ready), 32'(v.exp_src));
        @(negedge clk);
        drop_valids();
        #1;
        check($sformatf("v%0d_ext_rspv", idx), 32'(bus.rsp_valid), 32'd0);
        check($sformatf("v%0d_ext_data", idx), 32'(bus.ext_i_data), 32'(exp_op));
        check($sformatf("v%0d_ext_extop", idx), 32'(bus.ext_extop), 32'(exp_x));
        @(negedge clk);
        #1;
        check($sformatf("v%0d_rsp_valid", idx), 32'(bus.rsp_valid), 32'd1);
        check($sformatf("v%0d_rsp_data", idx), bus.rsp_data, v.exp_data);
        check($sformatf("v%0d_rsp_src", idx), 32'(bus.rsp_src), 32'(v.exp_src));
        check($sformatf("v%0d_rsp_tag", idx), 32'(bus.rsp_tag), 32'(v.exp_tag));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            v0   d0        e0    t0    v1    d1        e1    t1    src   data            tag
        tbl[0] = '{1'b1, 16'h8001, 1'b1, 4'h3, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b0, 32'hFFFF8001, 4'h3};
        tbl[1] = '{1'b0, 16'h0000, 1'b0, 4'h0, 1'b1, 16'h8001, 1'b0, 4'h5, 1'b1, 32'h00008001, 4'h5};
        tbl[2] = '{1'b0, 16'h0000, 1'b0, 4'h0, 1'b1, 16'h7FFF, 1'b1, 4'h9, 1'b1, 32'h00007FFF, 4'h9};
        tbl[3] = '{1'b1, 16'hFFFF, 1'b0, 4'hA, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b0, 32'h0000FFFF, 4'hA};
        tbl[4] = '{1'b1, 16'h1234, 1'b1, 4'h1, 1'b1, 16'h9000, 1'b1, 4'h2, 1'b1, 32'hFFFF9000, 4'h2};
        tbl[5] = '{1'b1, 16'hABCD, 1'b1, 4'h7, 1'b1, 16'h0001, 1'b0, 4'h8, 1'b0, 32'hFFFFABCD, 4'h7};
        tbl[6] = '{1'b0, 16'h0000, 1'b0, 4'h0, 1'b1, 16'hFFFF, 1'b1, 4'hF, 1'b1, 32'hFFFFFFFF, 4'hF};
        tbl[7] = '{1'b1, 16'h0000, 1'b1, 4'h0, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b0, 32'h00000000, 4'h0};

        // Reset with both requesters valid: nothing may be granted
        bus.req0_valid = 1'b1; bus.req0_data = 16'h1111; bus.req0_extop = 1'b1; bus.req0_tag = 4'h1;
        bus.req1_valid = 1'b1; bus.req1_data = 16'h2222; bus.req1_extop = 1'b1; bus.req1_tag = 4'h2;
        bus.rsp_ready  = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready0", 32'(bus.req0_ready), 32'd0);
        check("rst_ready1", 32'(bus.req1_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        check("rst_rsp_src", 32'(bus.rsp_src), 32'd0);
        check("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
        check("rst_ext_data", 32'(bus.ext_i_data), 32'd0);
        check("rst_ext_extop", 32'(bus.ext_extop), 32'd0);
        @(negedge clk);
        drop_valids();
        rst_n = 1'b1;

        // Directed single/tie transactions from IDLE
        for (int i = 0; i < 8; i++) begin
            run_vec(i, tbl[i]);
        end

        // Both requesters valid every cycle after reset: grants alternate
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_data = 16'h0101; bus.req0_extop = 1'b0; bus.req0_tag = 4'h1;
        bus.req1_valid = 1'b1; bus.req1_data = 16'h8080; bus.req1_extop = 1'b1; bus.req1_tag = 4'h2;
        bus.rsp_ready  = 1'b1;
        got = 0; cyc = 0; cnt0 = 0; cnt1 = 0;
        while (got < 20 && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
            if (bus.rsp_valid) begin
                src_seen[got]  = bus.rsp_src;
                data_seen[got] = bus.rsp_data;
                t_seen[got]    = cyc;
                if (bus.rsp_src) cnt1++; else cnt0++;
                got++;
            end
        end
        check("alt_count", 32'(got), 32'd20);
        for (int i = 0; i < got; i++) begin
            check($sformatf("alt_src_%0d", i), 32'(src_seen[i]), 32'(i % 2));
            check($sformatf("alt_data_%0d", i), data_seen[i], (i % 2 == 1) ? 32'hFFFF8080 : 32'h00000101);
            if (i > 0) begin
                check($sformatf("alt_gap_%0d", i), 32'(t_seen[i] - t_seen[i-1]), 32'(RSP_PERIOD));
            end
        end
        check("alt_cnt0", 32'(cnt0), 32'd10);
        check("alt_cnt1", 32'(cnt1), 32'd10);
        @(negedge clk);
        drop_valids();
        repeat (4) @(negedge clk);

        // Response backpressure: payload held, no grants while stalled
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_data = 16'h00F0; bus.req0_extop = 1'b1; bus.req0_tag = 4'h6;
        #1;
        check("bp_ready0", 32'(bus.req0_ready), 32'd1);
        @(negedge clk);
        bus.req1_valid = 1'b1; bus.req1_data = 16'h1111; bus.req1_extop = 1'b0; bus.req1_tag = 4'h7;
        bus.req0_data  = 16'h3333; bus.req0_tag = 4'h5;
        #1;
        wait_n = 0;
        while (!bus.rsp_valid && wait_n < 5) begin
            @(negedge clk);
            #1;
            wait_n++;
        end
        check("bp_rsp_arrived", 32'(bus.rsp_valid), 32'd1);
        held_data = bus.rsp_data;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valid_%0d", i), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("bp_data_%0d", i), bus.rsp_data, 32'h000000F0);
            check($sformatf("bp_stable_%0d", i), bus.rsp_data, held_data);
            check($sformatf("bp_src_%0d", i), 32'(bus.rsp_src), 32'd0);
            check($sformatf("bp_tag_%0d", i), 32'(bus.rsp_tag), 32'h6);
            check($sformatf("bp_ready0_%0d", i), 32'(bus.req0_ready), 32'd0);
            check($sformatf("bp_ready1_%0d", i), 32'(bus.req1_ready), 32'd0);
            @(negedge clk);
            #1;
        end
        drop_valids();
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_release_valid", 32'(bus.rsp_valid), 32'd1);
        @(negedge clk);
        #1;
        check("bp_after_1", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        check("bp_after_2", 32'(bus.rsp_valid), 32'd0);

        // Reset while in EXT: request discarded, tie priority back to req0
        run_vec(100, tbl[0]);
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_data = 16'h4444; bus.req0_extop = 1'b0; bus.req0_tag = 4'h4;
        #1;
        check("rx_ready0", 32'(bus.req0_ready), 32'd1);
        @(negedge clk);
        drop_valids();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rx_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rx_rsp_data", bus.rsp_data, 32'd0);
        check("rx_rsp_tag", 32'(bus.rsp_tag), 32'd0);
        check("rx_ext_data", 32'(bus.ext_i_data), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("rx_no_rsp_%0d", i), 32'(bus.rsp_valid), 32'd0);
        end
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_data = 16'h0002; bus.req0_extop = 1'b0; bus.req0_tag = 4'hB;
        bus.req1_valid = 1'b1; bus.req1_data = 16'h0003; bus.req1_extop = 1'b0; bus.req1_tag = 4'hC;
        #1;
        check("rx_tie_ready0", 32'(bus.req0_ready), 32'd1);
        check("rx_tie_ready1", 32'(bus.req1_ready), 32'd0);
        @(negedge clk);
        drop_valids();
        @(negedge clk);
        #1;
        check("rx_tie_valid", 32'(bus.rsp_valid), 32'd1);
        check("rx_tie_src", 32'(bus.rsp_src), 32'd0);
        check("rx_tie_tag", 32'(bus.rsp_tag), 32'hB);
        check("rx_tie_data", bus.rsp_data, 32'h00000002);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
